// File: rtl/gpu_pkg.sv
// Shared types and packing constants for the GPU texture write path.
// Two 12-bit pixels travel in three stream bytes.
package gpu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PIX_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_FIN  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/texture_loader.sv
// Unpacks a 12-bit-per-pixel byte stream into sequential texture memory writes.
// Byte order per pixel pair: p0[7:0], {p1[3:0], p0[11:8]}, p1[11:4].
module texture_loader
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COLOR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH-1:0]  pixel_count,
  input  logic                   abort,
  input  logic [BYTE_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDR_WIDTH-1:0]  waddr,
  output logic [COLOR_WIDTH-1:0] wcolor,
  output logic                   wen,
  output logic                   busy,
  output logic                   done
);

  if (COLOR_WIDTH != PIX_W) begin : g_bad_color_width
    $error("texture_loader: COLOR_WIDTH must be 12");
  end

  loader_state_t          r_state;
  loader_state_t          w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  r_remaining;
  logic [BYTE_W-1:0]      r_lo8;
  logic [NIB_W-1:0]       r_nib;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [COLOR_WIDTH-1:0] r_wcolor;
  logic                   r_wen;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_write;
  logic                   w_launch;
  logic [COLOR_WIDTH-1:0] w_color;

  // abort masks the handshake so it beats a byte arriving in the same cycle
  assign w_accept = in_valid & w_in_ready & ~abort;
  assign w_last   = (r_remaining == ADDR_WIDTH'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_next = (pixel_count == '0) ? ST_FIN : ST_B0;
        ST_B0:   if (w_accept) w_next = ST_B1;
        ST_B1:   if (w_accept) w_next = w_last ? ST_FIN : ST_B2;
        ST_B2:   if (w_accept) w_next = w_last ? ST_FIN : ST_B0;
        ST_FIN:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Output / datapath decode from the current state
  always_comb begin
    w_in_ready = 1'b0;
    w_write    = 1'b0;
    w_launch   = 1'b0;
    w_color    = {in_data, r_nib};
    case (r_state)
      ST_IDLE: w_launch = start & ~abort;
      ST_B0:   w_in_ready = 1'b1;
      ST_B1: begin
        w_in_ready = 1'b1;
        w_write    = w_accept;
        w_color    = {in_data[NIB_W-1:0], r_lo8};
      end
      ST_B2: begin
        w_in_ready = 1'b1;
        w_write    = w_accept;
      end
      default: ;
    endcase
  end

  // Transfer bookkeeping and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_lo8       <= '0;
      r_nib       <= '0;
      r_waddr     <= '0;
      r_wcolor    <= '0;
      r_wen       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wen  <= w_write;
      r_busy <= (w_next != ST_IDLE);
      r_done <= (r_state == ST_FIN) & ~abort;
      if (w_launch) begin
        r_addr      <= base_addr;
        r_remaining <= pixel_count;
      end
      if (w_write) begin
        r_waddr     <= r_addr;
        r_wcolor    <= w_color;
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - ADDR_WIDTH'(1);
      end
      if (w_accept && r_state == ST_B0) r_lo8 <= in_data;
      if (w_accept && r_state == ST_B1) r_nib <= in_data[BYTE_W-1:NIB_W];
    end
  end

  assign in_ready = w_in_ready;
  assign waddr    = r_waddr;
  assign wcolor   = r_wcolor;
  assign wen      = r_wen;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/texture_loader.md
Name: texture_loader

Overview:
- Write-side producer for the GPU texture memory. Converts a byte stream into sequential pixel writes on the waddr/wcolor/wen port.
- The byte stream comes from the CPU/bus bridge or a UART: packed 12-bit colours, 2 pixels per 3 bytes.
- Software programs a base address and pixel count, then pulses start. The block accepts bytes under a valid/ready handshake and emits one write per completed pixel.

Parameters:
- ADDR_WIDTH, 16, width of texture write address and of pixel_count.
- COLOR_WIDTH, 12, pixel width. Fixed at 12; elaboration error otherwise.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle pulse; latches base_addr and pixel_count when idle.
- base_addr  input  ADDR_WIDTH  first texel address.
- pixel_count  input  ADDR_WIDTH  number of pixels to write.
- abort  input  1  returns to IDLE and drops the partial pixel.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a byte this cycle.
- waddr  output  ADDR_WIDTH  write address.
- wcolor  output  COLOR_WIDTH  write data.
- wen  output  1  write strobe, single cycle per pixel.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (async): state=IDLE. waddr=0, wcolor=0, wen=0, in_ready=0, busy=0, done=0. Internal counters and byte holding register are also 0.
- Byte accept: in_valid & in_ready. in_ready = 1 in states B0, B1, B2 only; it is combinational from state.
- Packing, for pixels p0, p1:
  - byte0 = p0[7:0]
  - byte1 = {p1[3:0], p0[11:8]}
  - byte2 = p1[11:4]
- FSM states: IDLE, B0, B1, B2, FIN.
  - IDLE: on start, latch addr=base_addr and remaining=pixel_count. Go to FIN if pixel_count==0, else B0. start is ignored outside IDLE.
  - B0: on accept, store byte as lo8 and go to B1.
  - B1: on accept:
    - Register a write: wcolor={byte[3:0], lo8}, waddr=addr, wen=1.
    - Store byte[7:4] as nib, addr+=1, remaining-=1.
    - Go to FIN if remaining becomes 0, else B2.
  - B2: on accept:
    - Register a write: wcolor={byte, nib}, waddr=addr, wen=1.
    - addr+=1, remaining-=1.
    - Go to FIN if remaining becomes 0, else B0.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Latency: wen, waddr and wcolor are registered and appear the cycle after the accepting edge. wen deasserts the following cycle unless another pixel completes. waddr/wcolor hold their last value when wen=0.
- Odd pixel_count: the transfer ends after B1 of the last group. The trailing byte2 is never requested, so total bytes = ceil(3*N/2).
- busy=1 in B0, B1, B2 and FIN. Registered, it rises the cycle after start.
- Address arithmetic: modulo 2^ADDR_WIDTH, wrapping silently. Out-of-range addresses are not filtered here; texture memory discards them.
- in_valid low: the state holds indefinitely with no timeout.
- abort: takes priority over byte accept in the same cycle.
  - Next state IDLE with no done pulse. A pending write from the previous cycle still completes.
  - Any partially received pixel is discarded.
- start and abort in the same cycle while IDLE: abort wins and the start is ignored.
- Reset mid-transfer: immediate return to the reset values; no write is issued.

Decomposition:
- gpu_pkg holds the FSM state enum (loader_state_t) and the byte/pixel packing constants.
- No sub-module; a single flat module.

Test Plan:
- pixel_count=2, base=0x0100, bytes 0x34,0x12,0xAB.
  - Expect wen at 0x0100 with 0x234, then at 0x0101 with 0xAB1.
  - Expect a done pulse, then busy=0.
- pixel_count=3, bytes 0x34,0x12,0xAB,0xCD,0x0E.
  - Expect three writes: 0x234, 0xAB1, 0xECD.
  - in_ready drops after byte 5, for 5 bytes total.
- pixel_count=0 -> no wen; done one cycle after busy rises; zero bytes accepted.
- base=0xFFFF, pixel_count=2 -> writes at 0xFFFF then 0x0000.
- in_valid toggled randomly over 64 pixels -> 64 writes with consecutive addresses and data matching the reference packer.
- abort after byte1 of pixel 5 -> no further wen and no done. Then a new start completes normally. Assert rst mid-transfer -> all outputs are 0 immediately.
